// File: rtl/deposit_track_if.sv
// deposit_track bus: strobes and data in,
// register/net view and snapshot log out.
interface deposit_track_if #(
  parameter int W      = 8,
  parameter int LOG_AW = 4
);
  logic              wr_valid;
  logic [W-1:0]      wr_data;
  logic              dep_valid;
  logic [W-1:0]      dep_data;
  logic              frc_valid;
  logic [W-1:0]      frc_data;
  logic              rel_valid;
  logic [W-1:0]      q;
  logic [W-1:0]      y;
  logic              forced;
  logic              log_valid;
  logic              log_ready;
  logic [W-1:0]      log_q;
  logic [W-1:0]      log_y;
  logic              log_forced;
  logic [LOG_AW:0]   log_count;
  logic              log_overflow;

  modport master (
    output wr_valid, wr_data,
    output dep_valid, dep_data,
    output frc_valid, frc_data,
    output rel_valid, log_ready,
    input  q, y, forced,
    input  log_valid, log_q, log_y,
    input  log_forced, log_count,
    input  log_overflow
  );

  modport slave (
    input  wr_valid, wr_data,
    input  dep_valid, dep_data,
    input  frc_valid, frc_data,
    input  rel_valid, log_ready,
    output q, y, forced,
    output log_valid, log_q, log_y,
    output log_forced, log_count,
    output log_overflow
  );
endinterface

// File: rtl/deposit_track.sv
// Register + forceable net with deposit/force/release
// semantics and a FIFO log of per-event snapshots.
module deposit_track #(
  parameter int W      = 8,
  parameter int LOG_AW = 4
) (
  input logic             clk,
  input logic             rst_n,
  deposit_track_if.slave  bus
);

  localparam int DEPTH = 1 << LOG_AW;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] y;
    logic         f;
  } snap_t;

  typedef enum logic {
    FREE   = 1'b0,
    FORCED = 1'b1
  } st_t;

  st_t             state, state_nx;
  logic [W-1:0]    q_r;
  logic [W-1:0]    frc_val;
  logic            forced_c;
  logic [W-1:0]    y_c;
  logic            ev;
  logic            ev_d;

  snap_t           mem [DEPTH];
  logic [LOG_AW-1:0] wr_ptr;
  logic [LOG_AW-1:0] rd_ptr;
  logic [LOG_AW:0]   cnt;
  logic [LOG_AW:0]   cnt_nx;
  logic            ovf;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push_ok;
  snap_t           head;

  assign ev = bus.wr_valid | bus.dep_valid |
              bus.frc_valid | bus.rel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (bus.wr_valid) begin
      q_r <= bus.wr_data;
    end else if (bus.dep_valid) begin
      q_r <= bus.dep_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frc_val <= '0;
    end else if (bus.frc_valid) begin
      frc_val <= bus.frc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FREE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FREE:   if (bus.frc_valid) state_nx = FORCED;
      FORCED: if (bus.frc_valid) state_nx = FORCED;
              else if (bus.rel_valid) state_nx = FREE;
      default: state_nx = FREE;
    endcase
  end

  always_comb begin
    forced_c = (state == FORCED);
    y_c      = forced_c ? frc_val : q_r;
  end

  // Snapshot one edge late so it captures post-event state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ev_d <= 1'b0;
    else        ev_d <= ev;
  end

  assign full    = (cnt == (LOG_AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop     = !empty && bus.log_ready;
  assign push_ok = ev_d && (!full || pop);

  always_comb begin
    cnt_nx = cnt;
    unique case ({push_ok, pop})
      2'b10:   cnt_nx = cnt + 1'b1;
      2'b01:   cnt_nx = cnt - 1'b1;
      default: cnt_nx = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{q: q_r, y: y_c, f: forced_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nx;
      if (ev_d && full && !pop) ovf <= 1'b1;
    end
  end

  // Storage is not reset; gate the head so it reads 0 when empty.
  assign head = empty ? '0 : mem[rd_ptr];

  assign bus.q            = q_r;
  assign bus.y            = y_c;
  assign bus.forced       = forced_c;
  assign bus.log_valid    = !empty;
  assign bus.log_q        = head.q;
  assign bus.log_y        = head.y;
  assign bus.log_forced   = head.f;
  assign bus.log_count    = cnt;
  assign bus.log_overflow = ovf;

endmodule

// File: tb/tb_deposit_track.sv
// Directed bench for deposit_track.
// Drives strobes after each edge and checks #1 later.
module tb_deposit_track;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  deposit_track_if #(.W(8), .LOG_AW(4)) bus ();

  deposit_track #(.W(8), .LOG_AW(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.wr_valid  = 1'b0;
    bus.dep_valid = 1'b0;
    bus.frc_valid = 1'b0;
    bus.rel_valid = 1'b0;
    bus.log_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
  endtask

  task automatic pop();
    bus.log_ready = 1'b1;
    tick();
  endtask

  task automatic head(input string tag,
                      input logic [7:0] eq,
                      input logic [7:0] ey,
                      input logic ef);
    chk({tag, "_vld"}, 32'(bus.log_valid), 32'd1);
    chk({tag, "_q"}, 32'(bus.log_q), 32'(eq));
    chk({tag, "_y"}, 32'(bus.log_y), 32'(ey));
    chk({tag, "_f"}, 32'(bus.log_forced), 32'(ef));
  endtask

  initial begin
    clr();
    bus.wr_data  = '0;
    bus.dep_data = '0;
    bus.frc_data = '0;
    #22;
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_y", 32'(bus.y), 32'h0);
    chk("rst_forced", 32'(bus.forced), 32'h0);
    chk("rst_lvalid", 32'(bus.log_valid), 32'h0);
    chk("rst_lcount", 32'(bus.log_count), 32'h0);
    chk("rst_ovf", 32'(bus.log_overflow), 32'h0);
    chk("rst_lq", 32'(bus.log_q), 32'h0);
    chk("rst_ly", 32'(bus.log_y), 32'h0);
    chk("rst_lf", 32'(bus.log_forced), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // deposit then write
    bus.dep_valid = 1'b1;
    bus.dep_data  = 8'h01;
    tick();
    chk("dep_q", 32'(bus.q), 32'h01);
    chk("dep_y", 32'(bus.y), 32'h01);
    chk("dep_cnt0", 32'(bus.log_count), 32'h0);
    wr(8'h00);
    chk("wr0_q", 32'(bus.q), 32'h00);
    chk("wr0_cnt1", 32'(bus.log_count), 32'h1);
    tick();
    chk("t1_cnt", 32'(bus.log_count), 32'h2);
    head("t1_e0", 8'h01, 8'h01, 1'b0);
    pop();
    head("t1_e1", 8'h00, 8'h00, 1'b0);
    pop();
    chk("t1_empty", 32'(bus.log_valid), 32'h0);

    // force, writes underneath, release
    bus.frc_valid = 1'b1;
    bus.frc_data  = 8'hA5;
    tick();
    chk("frc_forced", 32'(bus.forced), 32'h1);
    chk("frc_y", 32'(bus.y), 32'hA5);
    wr(8'h11);
    chk("f11_q", 32'(bus.q), 32'h11);
    chk("f11_y", 32'(bus.y), 32'hA5);
    wr(8'h22);
    chk("f22_q", 32'(bus.q), 32'h22);
    chk("f22_y", 32'(bus.y), 32'hA5);
    bus.rel_valid = 1'b1;
    tick();
    chk("rel_forced", 32'(bus.forced), 32'h0);
    chk("rel_y", 32'(bus.y), 32'h22);
    tick();
    chk("t2_cnt", 32'(bus.log_count), 32'h4);
    head("t2_e0", 8'h00, 8'hA5, 1'b1);
    pop();
    head("t2_e1", 8'h11, 8'hA5, 1'b1);
    pop();
    head("t2_e2", 8'h22, 8'hA5, 1'b1);
    pop();
    head("t2_e3", 8'h22, 8'h22, 1'b0);
    pop();
    chk("t2_cnt0", 32'(bus.log_count), 32'h0);

    // all four strobes at once
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'h33;
    bus.dep_valid = 1'b1;
    bus.dep_data  = 8'h44;
    bus.frc_valid = 1'b1;
    bus.frc_data  = 8'h55;
    bus.rel_valid = 1'b1;
    tick();
    chk("all_q", 32'(bus.q), 32'h33);
    chk("all_y", 32'(bus.y), 32'h55);
    chk("all_forced", 32'(bus.forced), 32'h1);
    tick();
    tick();
    chk("all_cnt", 32'(bus.log_count), 32'h1);
    head("all_e0", 8'h33, 8'h55, 1'b1);
    pop();
    bus.rel_valid = 1'b1;
    tick();
    chk("rel2_y", 32'(bus.y), 32'h33);
    tick();
    head("rel2_e0", 8'h33, 8'h33, 1'b0);
    pop();
    chk("rel2_cnt0", 32'(bus.log_count), 32'h0);

    // rel in FREE is still an event
    bus.rel_valid = 1'b1;
    tick();
    chk("relfree_forced", 32'(bus.forced), 32'h0);
    tick();
    chk("relfree_cnt", 32'(bus.log_count), 32'h1);
    pop();

    // fill to exactly full, then one more
    for (int i = 0; i < 16; i++) wr(8'(i));
    tick();
    chk("full_cnt", 32'(bus.log_count), 32'd16);
    chk("full_ovf0", 32'(bus.log_overflow), 32'h0);
    wr(8'h10);
    tick();
    chk("ovf_cnt", 32'(bus.log_count), 32'd16);
    chk("ovf_set", 32'(bus.log_overflow), 32'h1);
    chk("ovf_q", 32'(bus.q), 32'h10);
    head("ovf_head", 8'h00, 8'h00, 1'b0);

    // full: push and pop together
    wr(8'hAA);
    pop();
    chk("pp_cnt", 32'(bus.log_count), 32'd16);
    chk("pp_ovf", 32'(bus.log_overflow), 32'h1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain_%0d", i),
          32'(bus.log_q), 32'(i));
      pop();
    end
    head("drain_tail", 8'hAA, 8'hAA, 1'b0);
    pop();
    chk("drain_empty", 32'(bus.log_valid), 32'h0);
    chk("drain_cnt", 32'(bus.log_count), 32'h0);

    // empty: push and pop together
    wr(8'h5A);
    pop();
    chk("ep_cnt", 32'(bus.log_count), 32'h1);
    head("ep_head", 8'h5A, 8'h5A, 1'b0);

    // reset while forced with 5 entries
    bus.frc_valid = 1'b1;
    bus.frc_data  = 8'h77;
    tick();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    tick();
    chk("pre_cnt", 32'(bus.log_count), 32'h5);
    chk("pre_forced", 32'(bus.forced), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_q", 32'(bus.q), 32'h0);
    chk("mr_y", 32'(bus.y), 32'h0);
    chk("mr_forced", 32'(bus.forced), 32'h0);
    chk("mr_cnt", 32'(bus.log_count), 32'h0);
    chk("mr_lvalid", 32'(bus.log_valid), 32'h0);
    chk("mr_lq", 32'(bus.log_q), 32'h0);
    chk("mr_ovf", 32'(bus.log_overflow), 32'h0);
    @(negedge clk);
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'hEE;
    bus.frc_valid = 1'b1;
    bus.frc_data  = 8'hEE;
    tick();
    chk("rstwr_q", 32'(bus.q), 32'h0);
    chk("rstwr_forced", 32'(bus.forced), 32'h0);
    chk("rstwr_cnt", 32'(bus.log_count), 32'h0);
    rst_n = 1'b1;
    wr(8'h9C);
    chk("post_y", 32'(bus.y), 32'h9C);
    chk("post_forced", 32'(bus.forced), 32'h0);
    tick();
    head("post_e0", 8'h9C, 8'h9C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
